// File: rtl/cmul_arbiter.sv
// Round-robin arbiter in front of one 3-stage pipelined Q1.(DW-1) complex multiplier.
// Results return in grant order with a one-hot tag naming the requester.
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

module cmul_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DW      = `DATA_IN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*DW-1:0] req_a_re,
   input  logic [NUM_REQ*DW-1:0] req_a_im,
   input  logic [NUM_REQ*DW-1:0] req_b_re,
   input  logic [NUM_REQ*DW-1:0] req_b_im,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]         rsp_re,
   output logic [DW-1:0]         rsp_im
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Full-precision signed product, floor-shifted back to Q1.(DW-1) and truncated.
   function automatic logic signed [DW-1:0] qmul(input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
      logic signed [2*DW-1:0] xe;
      logic signed [2*DW-1:0] ye;
      logic signed [2*DW-1:0] p;
      xe = $signed({{DW{x[DW-1]}}, x});
      ye = $signed({{DW{y[DW-1]}}, y});
      p  = xe * ye;
      return DW'(p >>> (DW-1));
   endfunction

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      sel;
   logic [NUM_REQ-1:0] grant;
   logic               transfer;
   logic [DW-1:0]      op_ar, op_ai, op_br, op_bi;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin : arbiter
      int            idx;
      logic [PW-1:0] idx_b;
      logic          found;
      grant = '0;
      sel   = ptr;
      found = 1'b0;
      idx   = 0;
      idx_b = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_b = PW'(idx);
         if (!found && req_valid[idx_b]) begin
            found        = 1'b1;
            grant[idx_b] = 1'b1;
            sel          = idx_b;
         end
      end
      if (flush) grant = '0;
   end

   assign req_ready = grant;
   assign transfer  = |(grant & req_valid);

   always_comb begin : operand_mux
      op_ar = '0;
      op_ai = '0;
      op_br = '0;
      op_bi = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            op_ar = req_a_re[i*DW +: DW];
            op_ai = req_a_im[i*DW +: DW];
            op_br = req_b_re[i*DW +: DW];
            op_bi = req_b_im[i*DW +: DW];
         end
      end
   end

   // Pointer starts at the last requester so requester 0 wins the first search.
   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PW'(NUM_REQ-1);
      end else if (transfer) begin
         ptr <= sel;
      end
   end

   // S1: registered operands and one-hot tag
   logic                     s1_valid;
   logic [NUM_REQ-1:0]       s1_tag;
   logic signed [DW-1:0]     s1_ar, s1_ai, s1_br, s1_bi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_tag   <= '0;
         s1_ar    <= '0;
         s1_ai    <= '0;
         s1_br    <= '0;
         s1_bi    <= '0;
      end else begin
         s1_valid <= transfer & ~flush;
         if (transfer) begin
            s1_tag <= grant;
            s1_ar  <= op_ar;
            s1_ai  <= op_ai;
            s1_br  <= op_br;
            s1_bi  <= op_bi;
         end
      end
   end

   // S2: four scaled partial products
   logic                     s2_valid;
   logic [NUM_REQ-1:0]       s2_tag;
   logic signed [DW-1:0]     s2_rr, s2_ii, s2_ri, s2_ir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_tag   <= '0;
         s2_rr    <= '0;
         s2_ii    <= '0;
         s2_ri    <= '0;
         s2_ir    <= '0;
      end else begin
         s2_valid <= s1_valid & ~flush;
         if (s1_valid) begin
            s2_tag <= s1_tag;
            s2_rr  <= qmul(s1_ar, s1_br);
            s2_ii  <= qmul(s1_ai, s1_bi);
            s2_ri  <= qmul(s1_ar, s1_bi);
            s2_ir  <= qmul(s1_ai, s1_br);
         end
      end
   end

   // S3: combine with modulo-2^DW wrap; result data holds while no result is presented
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_re    <= '0;
         rsp_im    <= '0;
      end else begin
         rsp_valid <= (s2_valid && !flush) ? s2_tag : '0;
         if (s2_valid && !flush) begin
            rsp_re <= s2_rr - s2_ii;
            rsp_im <= s2_ri + s2_ir;
         end
      end
   end

endmodule

// File: tb/tb_cmul_arbiter.sv
// Directed bench for cmul_arbiter: arbitration order, pipeline latency, Q1.15 scaling,
// wrap-around, flush and asynchronous reset.
module tb_cmul_arbiter;

   localparam int NUM_REQ = 2;
   localparam int DW      = 16;

   logic                  clk;
   logic                  rst_n;
   logic                  flush;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*DW-1:0] req_a_re, req_a_im, req_b_re, req_b_im;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [DW-1:0]         rsp_re, rsp_im;

   int         n_cmp;
   int         n_err;
   logic [1:0] g_exp;

   cmul_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a_re  (req_a_re),
      .req_a_im  (req_a_im),
      .req_b_re  (req_b_re),
      .req_b_im  (req_b_im),
      .rsp_valid (rsp_valid),
      .rsp_re    (rsp_re),
      .rsp_im    (rsp_im)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ops(input int i, input int ar, input int ai, input int br, input int bi);
      req_a_re[i*DW +: DW] = DW'(ar);
      req_a_im[i*DW +: DW] = DW'(ai);
      req_b_re[i*DW +: DW] = DW'(br);
      req_b_im[i*DW +: DW] = DW'(bi);
   endtask

   function automatic logic [1:0] alt_grant(input int c);
      return (c % 2 == 0) ? 2'b10 : 2'b01;
   endfunction

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      g_exp     = '0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_a_re  = '0;
      req_a_im  = '0;
      req_b_re  = '0;
      req_b_im  = '0;

      repeat (2) @(negedge clk);
      check("reset rsp_valid", DW'(rsp_valid), '0);
      check("reset rsp_re", rsp_re, '0);
      check("reset rsp_im", rsp_im, '0);
      check("reset ready idle", DW'(req_ready), '0);
      rst_n = 1'b1;
      step();

      // single transfer from requester 0
      set_ops(0, 16384, 0, 16384, 0);
      req_valid = 2'b01;
      #1 check("t1 ready", DW'(req_ready), DW'(2'b01));
      step();
      req_valid = '0;
      check("t1 T+1 none", DW'(rsp_valid), '0);
      step();
      check("t1 T+2 none", DW'(rsp_valid), '0);
      step();
      check("t1 T+3 tag", DW'(rsp_valid), DW'(2'b01));
      check("t1 re", rsp_re, DW'(8192));
      check("t1 im", rsp_im, DW'(0));
      step();
      check("t1 T+4 none", DW'(rsp_valid), '0);
      check("t1 re hold", rsp_re, DW'(8192));

      // back-to-back: j*j, floor of -1*1, and wrap of (-1)*(-1)
      set_ops(0, 0, 16384, 0, 16384);
      req_valid = 2'b01;
      #1 check("t2a ready", DW'(req_ready), DW'(2'b01));
      step();
      set_ops(0, -1, 0, 1, 0);
      #1 check("t2b ready", DW'(req_ready), DW'(2'b01));
      step();
      set_ops(0, -32768, 0, -32768, 0);
      #1 check("t3 ready", DW'(req_ready), DW'(2'b01));
      step();
      req_valid = '0;
      check("t2a tag", DW'(rsp_valid), DW'(2'b01));
      check("t2a re", rsp_re, DW'(-8192));
      check("t2a im", rsp_im, DW'(0));
      step();
      check("t2b tag", DW'(rsp_valid), DW'(2'b01));
      check("t2b re", rsp_re, DW'(-1));
      check("t2b im", rsp_im, DW'(0));
      step();
      check("t3 tag", DW'(rsp_valid), DW'(2'b01));
      check("t3 re wrap", rsp_re, DW'(-32768));
      check("t3 im", rsp_im, DW'(0));
      step();
      check("t3 drained", DW'(rsp_valid), '0);

      // both requesters valid for 8 cycles; pointer is at 0 so requester 1 goes first
      set_ops(0, 16384, 8192, 2048, 0);   // -> (1024, 512)
      set_ops(1, 16384, 0, 4096, -4096);  // -> (2048, -2048)
      for (int c = 0; c < 11; c++) begin
         req_valid = (c < 8) ? 2'b11 : 2'b00;
         #1;
         if (c < 8) check("t4 grant", DW'(req_ready), DW'(alt_grant(c)));
         if (c >= 3) begin
            g_exp = alt_grant(c - 3);
            check("t4 tag", DW'(rsp_valid), DW'(g_exp));
            check("t4 re", rsp_re, DW'((g_exp == 2'b01) ? 1024 : 2048));
            check("t4 im", rsp_im, DW'((g_exp == 2'b01) ? 512 : -2048));
         end else begin
            check("t4 no early rsp", DW'(rsp_valid), '0);
         end
         step();
      end
      check("t4 drained", DW'(rsp_valid), '0);

      // pointer moves only on a transfer
      req_valid = 2'b10;
      #1 check("t5 grant req1", DW'(req_ready), DW'(2'b10));
      step();
      req_valid = 2'b00;
      #1 check("t5 idle", DW'(req_ready), '0);
      step();
      req_valid = 2'b11;
      #1 check("t5 then req0", DW'(req_ready), DW'(2'b01));
      step();
      #1 check("t5 then req1", DW'(req_ready), DW'(2'b10));
      check("t5 first rsp tag", DW'(rsp_valid), DW'(2'b10));
      check("t5 first rsp re", rsp_re, DW'(2048));
      step();
      req_valid = '0;
      check("t5 gap", DW'(rsp_valid), '0);
      step();
      check("t5 req0 tag", DW'(rsp_valid), DW'(2'b01));
      check("t5 req0 re", rsp_re, DW'(1024));
      check("t5 req0 im", rsp_im, DW'(512));
      step();
      check("t5 req1 tag", DW'(rsp_valid), DW'(2'b10));
      check("t5 req1 re", rsp_re, DW'(2048));
      check("t5 req1 im", rsp_im, DW'(-2048));
      step();

      // flush the cycle after the second transfer: neither result may appear
      set_ops(1, 8192, 0, -16384, 0);     // -> (-4096, 0)
      req_valid = 2'b01;
      #1 check("t6 xfer A", DW'(req_ready), DW'(2'b01));
      step();
      #1 check("t6 xfer B", DW'(req_ready), DW'(2'b01));
      step();
      flush = 1'b1;
      #1 check("t6 no grant in flush", DW'(req_ready), '0);
      step();
      flush     = 1'b0;
      req_valid = 2'b11;
      #1 check("t6 ptr kept", DW'(req_ready), DW'(2'b10));
      check("t6 A dropped", DW'(rsp_valid), '0);
      check("t6 re held", rsp_re, DW'(2048));
      step();
      req_valid = '0;
      check("t6 B dropped", DW'(rsp_valid), '0);
      step();
      check("t6 quiet", DW'(rsp_valid), '0);
      step();
      check("t6 C tag", DW'(rsp_valid), DW'(2'b10));
      check("t6 C re", rsp_re, DW'(-4096));
      check("t6 C im", rsp_im, DW'(0));
      step();

      // asynchronous reset in the middle of a stream
      req_valid = 2'b01;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("rst rsp_valid", DW'(rsp_valid), '0);
      check("rst rsp_re", rsp_re, '0);
      check("rst rsp_im", rsp_im, '0);
      req_valid = '0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         check("rst work lost", DW'(rsp_valid), '0);
         step();
      end
      req_valid = 2'b11;
      #1 check("rst ptr req0 first", DW'(req_ready), DW'(2'b01));
      step();
      req_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
